// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and decoder state encoding.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned H_FRONT_PORCH = 16;
  localparam int unsigned H_SYNC_PULSE  = 96;
  localparam int unsigned H_BACK_PORCH  = 48;
  localparam int unsigned H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;

  localparam int unsigned V_ACTIVE      = 480;
  localparam int unsigned V_FRONT_PORCH = 10;
  localparam int unsigned V_SYNC_PULSE  = 2;
  localparam int unsigned V_BACK_PORCH  = 33;
  localparam int unsigned V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  // First column of the hsync pulse, first column after it, first vsync line.
  localparam int unsigned HSYNC_POS = H_ACTIVE + H_FRONT_PORCH;
  localparam int unsigned HSYNC_END = HSYNC_POS + H_SYNC_PULSE;
  localparam int unsigned VSYNC_POS = V_ACTIVE + V_FRONT_PORCH;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HALIGN = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  // 10-bit counter step that wraps from last back to zero.
  function automatic logic [9:0] wrap_inc(input logic [9:0] value, input logic [9:0] last);
    return (value == last) ? 10'd0 : value + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Falling/rising edge detector for one active-low sync line.
module vga_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sync_in,
  output logic fall,
  output logic rise
);

  logic sync_prev;

  // Previous sample; resets high so an idle (high) line shows no edge.
  always_ff @(posedge clock) begin
    if (reset) sync_prev <= 1'b1;
    else       sync_prev <= sync_in;
  end

  assign fall = sync_prev & ~sync_in;
  assign rise = ~sync_prev & sync_in;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receiver: locks onto hsync/vsync timing and re-emits active pixels
// with recovered row/column, one clock after the sample is taken.
//
// state  | meaning
// SEARCH | no horizontal reference; waiting for an hsync fall
// HALIGN | column count aligned to hsync; waiting for a vsync fall at col 0
// LOCKED | both counters aligned; every sync edge is checked against them
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT_PORCH = vga_timing_pkg::H_FRONT_PORCH,
  parameter int unsigned H_SYNC_PULSE  = vga_timing_pkg::H_SYNC_PULSE,
  parameter int unsigned H_TOTAL       = vga_timing_pkg::H_TOTAL,
  parameter int unsigned V_ACTIVE      = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT_PORCH = vga_timing_pkg::V_FRONT_PORCH,
  parameter int unsigned V_TOTAL       = vga_timing_pkg::V_TOTAL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vga_hsync,
  input  logic       vga_vsync,
  input  logic [2:0] vga_rgb,
  output logic [9:0] pixel_row,
  output logic [9:0] pixel_col,
  output logic [2:0] pixel_rgb,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_error
);

  localparam logic [9:0] HS_POS = 10'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [9:0] VS_POS = 10'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

  sync_state_t state_q, state_d;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic        hfall, hrise, vfall;
  logic        vsync_rise_unused;
  logic        at_hs_pos, at_vs_pos, lock_err, timing_err, valid_d;

  vga_edge_detect u_hsync_edge (
    .clock   (clock),
    .reset   (reset),
    .sync_in (vga_hsync),
    .fall    (hfall),
    .rise    (hrise)
  );

  // The end of the vsync pulse carries no timing check.
  vga_edge_detect u_vsync_edge (
    .clock   (clock),
    .reset   (reset),
    .sync_in (vga_vsync),
    .fall    (vfall),
    .rise    (vsync_rise_unused)
  );

  assign at_hs_pos = (hc_q == HS_POS);
  assign at_vs_pos = (hc_q == 10'd0) && (vc_q == VS_POS);

  // hfall must coincide with HS_POS in both directions, so a late or early
  // edge and a missing edge share one term; all checks merge to one pulse.
  assign lock_err = (hfall != at_hs_pos)
                  | (hrise & (hc_q != HS_END))
                  | (vfall & ~at_vs_pos)
                  | (at_vs_pos & vga_vsync);

  assign valid_d = (state_q == LOCKED) && (hc_q < H_ACT) && (vc_q < V_ACT);

  // State register and sample-position counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEARCH;
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
    end
  end

  // Next state and counter realignment; counters free-run unless a sync edge re-seeds them.
  always_comb begin
    state_d    = state_q;
    hc_d       = wrap_inc(hc_q, H_LAST);
    vc_d       = (hc_q == H_LAST) ? wrap_inc(vc_q, V_LAST) : vc_q;
    timing_err = 1'b0;
    case (state_q)
      SEARCH: begin
        if (hfall) begin
          hc_d    = HS_POS + 10'd1;
          vc_d    = vc_q;
          state_d = HALIGN;
        end
      end
      HALIGN: begin
        if (vfall) begin
          if (hc_q == 10'd0) begin
            hc_d    = 10'd1;
            vc_d    = VS_POS;
            state_d = LOCKED;
          end else begin
            timing_err = 1'b1;
            state_d    = SEARCH;
          end
        end else if (hfall && !at_hs_pos) begin
          timing_err = 1'b1;
          hc_d       = HS_POS + 10'd1;
          vc_d       = vc_q;
        end
      end
      LOCKED: begin
        timing_err = lock_err;
        if (lock_err) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Single output stage: everything describes the sample consumed at this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_row   <= 10'd0;
      pixel_col   <= 10'd0;
      pixel_rgb   <= 3'b000;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      pixel_row   <= vc_q;
      pixel_col   <= hc_q;
      pixel_rgb   <= valid_d ? vga_rgb : 3'b000;
      pixel_valid <= valid_d;
      frame_start <= (state_q == LOCKED) && (hc_q == 10'd0) && (vc_q == 10'd0);
      locked      <= (state_d == LOCKED);
      sync_error  <= timing_err;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken raster so whole frames stay short.
module tb_vga_sync_decoder;

  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HSP = 8;
  localparam int HBP = 4;
  localparam int HT  = HA + HFP + HSP + HBP;   // 56
  localparam int VA  = 30;
  localparam int VFP = 3;
  localparam int VSP = 2;
  localparam int VBP = 3;
  localparam int VT  = VA + VFP + VSP + VBP;   // 38
  localparam int HS_POS = HA + HFP;            // 44
  localparam int HS_END = HS_POS + HSP;        // 52
  localparam int VS_POS = VA + VFP;            // 33
  localparam int FRAME  = HT * VT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vga_hsync = 1'b1;
  logic       vga_vsync = 1'b1;
  logic [2:0] vga_rgb = 3'b000;
  logic [9:0] pixel_row, pixel_col;
  logic [2:0] pixel_rgb;
  logic       pixel_valid, frame_start, locked, sync_error;

  vga_sync_decoder #(
    .H_ACTIVE      (HA),
    .H_FRONT_PORCH (HFP),
    .H_SYNC_PULSE  (HSP),
    .H_TOTAL       (HT),
    .V_ACTIVE      (VA),
    .V_FRONT_PORCH (VFP),
    .V_TOTAL       (VT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_rgb     (vga_rgb),
    .pixel_row   (pixel_row),
    .pixel_col   (pixel_col),
    .pixel_rgb   (pixel_rgb),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_error  (sync_error)
  );

  always #20 clock = ~clock;

  typedef struct {
    int         row;
    int         col;
    logic [2:0] rgb;
    logic [2:0] exp_rgb;
    logic       exp_valid;
    logic       exp_fs;
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad   = 0;
  int tx_h, tx_v, cur_h, cur_v;
  int fault_line = -1;
  int fault_mode = 0;        // 1: hsync fall one clock late, 2: hsync pulse one clock short
  bit vs_suppress = 1'b0;
  int se_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sample row %0d col %0d)", name, act, exp, cur_v, cur_h);
    end
  endtask

  function automatic logic [31:0] pk(input int row, input int col, input logic [2:0] rgb,
                                     input logic v, input logic fs, input logic l, input logic e);
    return {5'b0, 10'(row), 10'(col), rgb, v, fs, l, e};
  endfunction

  function automatic logic [31:0] out_pk();
    return {5'b0, pixel_row, pixel_col, pixel_rgb, pixel_valid, frame_start, locked, sync_error};
  endfunction

  function automatic logic [2:0] bg_rgb(input int v, input int h);
    return (h < HA && v < VA) ? 3'b000 : 3'b111;
  endfunction

  // Drive one transmitter sample, let the DUT take it, then look at its outputs.
  task automatic drive_cycle(input logic [2:0] rgb);
    logic hl;
    hl = (tx_h >= HS_POS) && (tx_h < HS_END);
    if (tx_v == fault_line && fault_mode == 1) hl = (tx_h >= HS_POS + 1) && (tx_h < HS_END);
    if (tx_v == fault_line && fault_mode == 2) hl = (tx_h >= HS_POS) && (tx_h < HS_END - 1);
    vga_hsync = ~hl;
    vga_vsync = vs_suppress ? 1'b1 : ~((tx_v >= VS_POS) && (tx_v < VS_POS + VSP));
    vga_rgb   = rgb;
    @(posedge clock);
    #1;
    cur_h = tx_h;
    cur_v = tx_v;
    if (sync_error) se_count++;
    tx_h++;
    if (tx_h == HT) begin
      tx_h = 0;
      tx_v = (tx_v == VT - 1) ? 0 : tx_v + 1;
    end
  endtask

  task automatic goto(input int row, input int col);
    int n;
    n = 0;
    while (!(tx_v == row && tx_h == col) && n < 2 * FRAME) begin
      drive_cycle(bg_rgb(tx_v, tx_h));
      n++;
    end
    if (n >= 2 * FRAME) chk("goto_reached", 32'(n), 32'(0));
  endtask

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    while (!locked && n < FRAME + HT + 4) begin
      drive_cycle(bg_rgb(tx_v, tx_h));
      n++;
    end
    if (locked) chk(name, pk(cur_v, cur_h, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0), pk(VS_POS, 0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    else        chk({name, "_timeout"}, 32'(locked), 32'(1));
    se_count = 0;
  endtask

  initial begin
    int n_valid, n_hit, hit_row, hit_col, vmis, blank_nz, pos_mis, fs_mis;

    vecs[0] = '{0,  0,  3'd7, 3'd7, 1'b1, 1'b1};
    vecs[1] = '{0,  1,  3'd2, 3'd2, 1'b1, 1'b0};
    vecs[2] = '{0,  39, 3'd3, 3'd3, 1'b1, 1'b0};
    vecs[3] = '{0,  40, 3'd7, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{10, 20, 3'd5, 3'd5, 1'b1, 1'b0};
    vecs[5] = '{29, 39, 3'd6, 3'd6, 1'b1, 1'b0};
    vecs[6] = '{30, 0,  3'd7, 3'd0, 1'b0, 1'b0};
    vecs[7] = '{37, 55, 3'd7, 3'd0, 1'b0, 1'b0};

    // Reset held while the transmitter runs mid-line.
    tx_v = 5;
    tx_h = 10;
    reset = 1'b1;
    repeat (3) drive_cycle(bg_rgb(tx_v, tx_h));
    chk("reset_outputs", out_pk(), 32'(0));
    reset = 1'b0;
    wait_lock("first_lock_pos");

    // Table of single samples across one locked frame.
    for (int i = 0; i < 8; i++) begin
      goto(vecs[i].row, vecs[i].col);
      drive_cycle(vecs[i].rgb);
      chk($sformatf("vec%0d", i), out_pk(),
          pk(vecs[i].row, vecs[i].col, vecs[i].exp_rgb, vecs[i].exp_valid, vecs[i].exp_fs, 1'b1, 1'b0));
    end
    chk("table_no_sync_error", 32'(se_count), 32'(0));

    // Whole frame with a single coloured pixel at (10,20); blanking driven non-zero.
    n_valid = 0; n_hit = 0; hit_row = -1; hit_col = -1;
    vmis = 0; blank_nz = 0; pos_mis = 0; fs_mis = 0;
    goto(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      drive_cycle((tx_v == 10 && tx_h == 20) ? 3'b101 : bg_rgb(tx_v, tx_h));
      if (pixel_valid) n_valid++;
      if (pixel_rgb == 3'b101) begin
        n_hit++;
        hit_row = int'(pixel_row);
        hit_col = int'(pixel_col);
      end
      if (pixel_valid != ((cur_h < HA) && (cur_v < VA))) vmis++;
      if (!pixel_valid && pixel_rgb != 3'b000) blank_nz++;
      if (pixel_row != 10'(cur_v) || pixel_col != 10'(cur_h)) pos_mis++;
      if (frame_start != (cur_v == 0 && cur_h == 0)) fs_mis++;
    end
    chk("frame_valid_count", 32'(n_valid), 32'(HA * VA));
    chk("frame_hit_count", 32'(n_hit), 32'(1));
    chk("frame_hit_pos", 32'((hit_row << 16) | hit_col), 32'((10 << 16) | 20));
    chk("frame_valid_mismatches", 32'(vmis), 32'(0));
    chk("frame_blank_rgb", 32'(blank_nz), 32'(0));
    chk("frame_pos_mismatches", 32'(pos_mis), 32'(0));
    chk("frame_fs_mismatches", 32'(fs_mis), 32'(0));
    chk("frame_no_sync_error", 32'(se_count), 32'(0));

    // hsync fall one clock late on line 5.
    fault_line = 5;
    fault_mode = 1;
    goto(5, 43);
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("late_hs_before", {30'b0, sync_error, locked}, 32'b01);
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("late_hs_missing", {30'b0, sync_error, locked}, 32'b10);
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("late_hs_after", {30'b0, sync_error, locked}, 32'b00);
    fault_mode = 0;
    wait_lock("late_hs_relock_pos");

    // hsync pulse one clock short on line 7: rise arrives at HS_END-1.
    fault_line = 7;
    fault_mode = 2;
    goto(7, 50);
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("short_hs_before", {30'b0, sync_error, locked}, 32'b01);
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("short_hs_rise", {30'b0, sync_error, locked}, 32'b10);
    fault_mode = 0;
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("short_hs_after", {30'b0, sync_error, locked}, 32'b00);
    wait_lock("short_hs_relock_pos");

    // One-clock reset while locked in the middle of row 20.
    goto(20, 10);
    reset = 1'b1;
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("reset_mid_frame", out_pk(), 32'(0));
    reset = 1'b0;
    wait_lock("reset_relock_pos");

    // vsync held high for a whole frame.
    goto(32, 55);
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("no_vs_before", {30'b0, sync_error, locked}, 32'b01);
    vs_suppress = 1'b1;
    drive_cycle(bg_rgb(tx_v, tx_h));
    chk("no_vs_error", {30'b0, sync_error, locked}, 32'b10);
    goto(32, 55);
    chk("no_vs_stays_unlocked", 32'(locked), 32'(0));
    vs_suppress = 1'b0;
    wait_lock("no_vs_relock_pos");

    goto(VS_POS, 0);
    chk("final_no_sync_error", 32'(se_count), 32'(0));
    chk("final_locked", 32'(locked), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
